// File: rtl/seq_lock_pkg.sv
// Shared state codes and widths for the sequence-lock supervisory controller.
package seq_lock_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned FAIL_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_UNLOCK  = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_e;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the armed, unlock and lockout states.
module lock_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    // A load in the same cycle masks a stale zero from the previous state.
    assign expired = (count == '0) && !load;

endmodule

// File: rtl/seq_lock_ctrl.sv
// Supervisory FSM for the two-button sequence lock: arm, timeout, fail count, lockout.
// Optional macro SEQ_LOCK_AUTO_REARM_EN: a non-lockout failure re-arms directly.
module seq_lock_ctrl
    import seq_lock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned UNLOCK_CYC  = 5000,
    parameter int unsigned LOCKOUT_CYC = 10000,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned TMR_W       = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               arm,
    input  logic               relock,
    input  logic               key_evt,
    input  logic               det_out,
    output logic               det_clr,
    output logic               unlocked,
    output logic               lockout,
    output logic [FAIL_W-1:0]  fail_cnt,
    output logic [STATE_W-1:0] state
);

    localparam logic [TMR_W-1:0]  TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  UNLOCK_LD  = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0]  LOCKOUT_LD = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAIL);

    state_e             state_q;
    state_e             state_nxt;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expired;
    logic               fail_inc;
    logic               fail_clr;
    logic [FAIL_W:0]    fail_plus1;

    lock_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign fail_plus1 = {1'b0, fail_cnt} + (FAIL_W+1)'(1);

    // State register plus Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            det_clr  <= 1'b1;
            unlocked <= 1'b0;
            lockout  <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            det_clr  <= (state_nxt != S_ARMED);
            unlocked <= (state_nxt == S_UNLOCK);
            lockout  <= (state_nxt == S_LOCKOUT);
        end
    end

    // Consecutive failure counter, saturating at MAX_FAIL.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fail_cnt <= '0;
        end else if (fail_clr) begin
            fail_cnt <= '0;
        end else if (fail_inc && (fail_cnt != FAIL_MAX)) begin
            fail_cnt <= fail_cnt + FAIL_W'(1);
        end
    end

    // Next-state, timer load and fail-count control.
    always_comb begin
        state_nxt = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        fail_inc  = 1'b0;
        fail_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_nxt = S_ARMED;
                    tmr_load  = 1'b1;
                    tmr_val   = TIMEOUT_LD;
                end
            end
            S_ARMED: begin
                if (det_out) begin
                    state_nxt = S_UNLOCK;
                    tmr_load  = 1'b1;
                    tmr_val   = UNLOCK_LD;
                    fail_clr  = 1'b1;
                end else if (tmr_expired) begin
                    state_nxt = S_FAIL;
                end else if (key_evt) begin
                    tmr_load  = 1'b1;
                    tmr_val   = TIMEOUT_LD;
                end
            end
            S_FAIL: begin
                fail_inc = 1'b1;
                if (fail_plus1 >= (FAIL_W+1)'(MAX_FAIL)) begin
                    state_nxt = S_LOCKOUT;
                    tmr_load  = 1'b1;
                    tmr_val   = LOCKOUT_LD;
                end else begin
`ifdef SEQ_LOCK_AUTO_REARM_EN
                    state_nxt = S_ARMED;
                    tmr_load  = 1'b1;
                    tmr_val   = TIMEOUT_LD;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            S_UNLOCK: begin
                if (relock || tmr_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (tmr_expired) begin
                    state_nxt = S_IDLE;
                    fail_clr  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Directed self-checking bench for seq_lock_ctrl (short timer parameters).
module tb_seq_lock_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       arm = 1'b0;
    logic       relock = 1'b0;
    logic       key_evt = 1'b0;
    logic       det_out = 1'b0;
    logic       det_clr;
    logic       unlocked;
    logic       lockout;
    logic [2:0] fcnt;
    logic [2:0] st;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, UNLK = 3'd2, FAILS = 3'd3, LOCK = 3'd4;
`ifdef SEQ_LOCK_AUTO_REARM_EN
    localparam logic [2:0] AFTER_FAIL = ARMED;
`else
    localparam logic [2:0] AFTER_FAIL = IDLE;
`endif

    seq_lock_ctrl #(
        .TIMEOUT_CYC (8),
        .UNLOCK_CYC  (6),
        .LOCKOUT_CYC (10),
        .MAX_FAIL    (3),
        .TMR_W       (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .arm      (arm),
        .relock   (relock),
        .key_evt  (key_evt),
        .det_out  (det_out),
        .det_clr  (det_clr),
        .unlocked (unlocked),
        .lockout  (lockout),
        .fail_cnt (fcnt),
        .state    (st)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(2);
        n_cmp++; if (st !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", st, IDLE); end
        n_cmp++; if (det_clr !== 1'b1) begin n_err++; $display("FAIL rst_det_clr: got %b want 1", det_clr); end
        n_cmp++; if (unlocked !== 1'b0 || lockout !== 1'b0) begin n_err++; $display("FAIL rst_flags: got %b%b want 00", unlocked, lockout); end
        n_cmp++; if (fcnt !== 3'd0) begin n_err++; $display("FAIL rst_fail_cnt: got %0d want 0", fcnt); end
        resetn = 1'b1;
        key_evt = 1'b1;
        relock = 1'b1;
        tick();
        key_evt = 1'b0;
        relock = 1'b0;
        n_cmp++; if (st !== IDLE) begin n_err++; $display("FAIL idle_ignores: got %0d want %0d", st, IDLE); end
    endtask

    task automatic test_success();
        pulse_arm();
        n_cmp++; if (st !== ARMED || det_clr !== 1'b0) begin n_err++; $display("FAIL arm: got st=%0d clr=%b want st=1 clr=0", st, det_clr); end
        tick(2);
        det_out = 1'b1;
        tick();
        det_out = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (st !== UNLK || unlocked !== 1'b1 || det_clr !== 1'b1) begin
                n_err++; $display("FAIL unlock_hold[%0d]: got st=%0d unl=%b clr=%b want st=2 unl=1 clr=1", i, st, unlocked, det_clr);
            end
            tick();
        end
        n_cmp++; if (st !== IDLE || unlocked !== 1'b0) begin n_err++; $display("FAIL unlock_end: got st=%0d unl=%b want st=0 unl=0", st, unlocked); end
        n_cmp++; if (fcnt !== 3'd0) begin n_err++; $display("FAIL success_fail_cnt: got %0d want 0", fcnt); end
    endtask

    task automatic test_timeout();
        pulse_arm();
        for (int c = 1; c <= 18; c++) begin
            key_evt = (c == 5 || c == 10);
            tick();
            key_evt = 1'b0;
            if (c == 17) begin
                n_cmp++; if (st !== ARMED) begin n_err++; $display("FAIL to_c17: got %0d want %0d", st, ARMED); end
            end
        end
        n_cmp++; if (st !== FAILS || det_clr !== 1'b1) begin n_err++; $display("FAIL to_c18: got st=%0d clr=%b want st=3 clr=1", st, det_clr); end
        tick();
        n_cmp++; if (st !== AFTER_FAIL) begin n_err++; $display("FAIL to_after: got %0d want %0d", st, AFTER_FAIL); end
        n_cmp++; if (fcnt !== 3'd1) begin n_err++; $display("FAIL to_fail_cnt: got %0d want 1", fcnt); end
        n_cmp++; if (det_clr !== (AFTER_FAIL != ARMED)) begin n_err++; $display("FAIL to_det_clr: got %b want %b", det_clr, AFTER_FAIL != ARMED); end
    endtask

    task automatic test_reset_mid();
`ifndef SEQ_LOCK_AUTO_REARM_EN
        pulse_arm();
`endif
        tick(2);
        n_cmp++; if (st !== ARMED || fcnt !== 3'd1) begin n_err++; $display("FAIL mid_pre: got st=%0d cnt=%0d want st=1 cnt=1", st, fcnt); end
        resetn = 1'b0;
        #2;
        n_cmp++; if (st !== IDLE || det_clr !== 1'b1 || fcnt !== 3'd0) begin
            n_err++; $display("FAIL mid_async: got st=%0d clr=%b cnt=%0d want st=0 clr=1 cnt=0", st, det_clr, fcnt);
        end
        resetn = 1'b1;
        tick(2);
        n_cmp++; if (st !== IDLE) begin n_err++; $display("FAIL mid_release: got %0d want 0", st); end
    endtask

    task automatic test_lockout();
        pulse_arm();
        tick(8);
        n_cmp++; if (st !== FAILS) begin n_err++; $display("FAIL lo_fail1: got %0d want %0d", st, FAILS); end
        for (int a = 2; a <= 3; a++) begin
            tick();
            n_cmp++; if (st !== AFTER_FAIL || fcnt !== 3'(a - 1)) begin
                n_err++; $display("FAIL lo_after%0d: got st=%0d cnt=%0d want st=%0d cnt=%0d", a, st, fcnt, AFTER_FAIL, a - 1);
            end
`ifndef SEQ_LOCK_AUTO_REARM_EN
            pulse_arm();
`endif
            n_cmp++; if (st !== ARMED || det_clr !== 1'b0) begin n_err++; $display("FAIL lo_rearm%0d: got st=%0d clr=%b want st=1 clr=0", a, st, det_clr); end
            tick(8);
            n_cmp++; if (st !== FAILS) begin n_err++; $display("FAIL lo_fail%0d: got %0d want %0d", a, st, FAILS); end
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (st !== LOCK || lockout !== 1'b1 || fcnt !== 3'd3) begin
                n_err++; $display("FAIL lo_hold[%0d]: got st=%0d lo=%b cnt=%0d want st=4 lo=1 cnt=3", i, st, lockout, fcnt);
            end
            arm = (i == 3 || i == 6);
            tick();
            arm = 1'b0;
        end
        n_cmp++; if (st !== IDLE || lockout !== 1'b0 || fcnt !== 3'd0) begin
            n_err++; $display("FAIL lo_exit: got st=%0d lo=%b cnt=%0d want st=0 lo=0 cnt=0", st, lockout, fcnt);
        end
    endtask

    task automatic test_simultaneous();
        pulse_arm();
        tick(8);
        tick();
`ifndef SEQ_LOCK_AUTO_REARM_EN
        pulse_arm();
`endif
        n_cmp++; if (st !== ARMED || fcnt !== 3'd1) begin n_err++; $display("FAIL sim_pre: got st=%0d cnt=%0d want st=1 cnt=1", st, fcnt); end
        tick(7);
        n_cmp++; if (st !== ARMED) begin n_err++; $display("FAIL sim_last_armed: got %0d want 1", st); end
        det_out = 1'b1;
        tick();
        det_out = 1'b0;
        n_cmp++; if (st !== UNLK || unlocked !== 1'b1 || fcnt !== 3'd0) begin
            n_err++; $display("FAIL sim_unlock: got st=%0d unl=%b cnt=%0d want st=2 unl=1 cnt=0", st, unlocked, fcnt);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_cmp++; if (st !== UNLK) begin n_err++; $display("FAIL sim_arm_ignored: got %0d want 2", st); end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        n_cmp++; if (st !== IDLE || unlocked !== 1'b0) begin n_err++; $display("FAIL sim_relock: got st=%0d unl=%b want st=0 unl=0", st, unlocked); end
    endtask

    initial begin
        test_reset();
        test_success();
        test_timeout();
        test_reset_mid();
        test_lockout();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_lock_ctrl.md
Name: seq_lock_ctrl

Overview:
- Supervisory controller for the two-button sequence-detector lock.
- Arms the detector and clears it between attempts.
- Times out stalled entry attempts and counts failures, entering a timed lockout after MAX_FAIL failures.
- Holds the unlocked condition for a bounded time.
- Sits between the panel logic (arm/relock) and the detector (its 1-bit accept output and a key-event pulse).

Parameters:
- TIMEOUT_CYC, 1000: cycles allowed with no key event while armed before the attempt fails.
- UNLOCK_CYC, 5000: cycles the unlocked state is held.
- LOCKOUT_CYC, 10000: cycles of lockout after MAX_FAIL failures.
- MAX_FAIL, 3: consecutive failures that trigger lockout; legal range 1..7.
- TMR_W, 16: timer width; must hold max(TIMEOUT_CYC, UNLOCK_CYC, LOCKOUT_CYC).

Ports:
- clk  in  1  system clock, posedge.
- resetn  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse: start an entry attempt.
- relock  in  1  one-cycle pulse: leave the unlocked state early.
- key_evt  in  1  one-cycle pulse per synchronized key press accepted by the detector.
- det_out  in  1  detector accept output (level).
- det_clr  out  1  synchronous clear to the detector, active high.
- unlocked  out  1  high in S_UNLOCK.
- lockout  out  1  high in S_LOCKOUT.
- fail_cnt  out  3  consecutive failure count.
- state  out  3  current state code, for debug/LEDs.

Behaviour:
- Reset (async, resetn=0):
  - state=S_IDLE, timer=0, fail_cnt=0.
  - Outputs: det_clr=1, unlocked=0, lockout=0.
  - Reset mid-operation aborts any attempt or lockout immediately.
- State codes: S_IDLE=0, S_ARMED=1, S_UNLOCK=2, S_FAIL=3, S_LOCKOUT=4. Any other code returns to S_IDLE next cycle.
- Outputs are Moore, decoded from registered state:
  - det_clr=1 in every state except S_ARMED.
  - unlocked=(state==S_UNLOCK).
  - lockout=(state==S_LOCKOUT).
- Timer: a down-counter loaded with N-1 on entry to a timed state. It expires when it reads 0 while still in that state. A timed state therefore lasts exactly N cycles unless left early.
- S_IDLE: arm=1 moves to S_ARMED and loads TIMEOUT_CYC. key_evt and relock are ignored.
- S_ARMED:
  - Priority 1: det_out=1 moves to S_UNLOCK, loads UNLOCK_CYC and clears fail_cnt to 0.
  - Priority 2: timer expiry moves to S_FAIL.
  - Priority 3: key_evt=1 reloads TIMEOUT_CYC (inactivity timeout, not total-attempt timeout).
  - arm is ignored; it does not reload the timer.
  - det_out and expiry in the same cycle resolve to S_UNLOCK.
- S_FAIL: one cycle.
  - fail_cnt increments. fail_cnt never exceeds MAX_FAIL; no wrap-around.
  - If fail_cnt+1==MAX_FAIL, go to S_LOCKOUT and load LOCKOUT_CYC; otherwise go to S_IDLE.
- S_UNLOCK: relock=1 or timer expiry moves to S_IDLE. arm is ignored.
- S_LOCKOUT: all inputs are ignored. Timer expiry moves to S_IDLE and clears fail_cnt to 0.
- Latency: a det_out rising edge in S_ARMED shows as unlocked=1 on the next clock edge (1 cycle).

Optional Feature:
- Macro SEQ_LOCK_AUTO_REARM_EN.
- Defined: when S_FAIL does not enter lockout, it goes directly to S_ARMED and reloads TIMEOUT_CYC. The detector sees det_clr for exactly one cycle (the S_FAIL cycle).
- Undefined: S_FAIL goes to S_IDLE and waits for a new arm pulse.

Decomposition:
- Shared package (seq_lock_pkg) holds:
  - the state code localparams S_IDLE..S_LOCKOUT;
  - the state width (3);
  - the fail_cnt width (3).
- One natural sub-module: lock_timer. It is a loadable down-counter with inputs clk, resetn, load, load_val[TMR_W-1:0] and output expired (count==0 and not loading). It is reused for all three timed states.

Test Plan:
All tests use TIMEOUT_CYC=8, UNLOCK_CYC=6, LOCKOUT_CYC=10, MAX_FAIL=3.
- Reset: assert resetn=0 mid-S_ARMED -> state=0, det_clr=1, fail_cnt=0 with no clock edge required; release -> remains S_IDLE.
- Successful entry: arm pulse, then det_out=1 after 3 cycles -> unlocked=1 next cycle for exactly 6 cycles, then S_IDLE; fail_cnt=0.
- Inactivity timeout: arm, with key_evt at cycles 5 and 10 and no det_out -> S_FAIL reached 8 cycles after the last key_evt (cycle 18); fail_cnt=1; S_IDLE after it.
- Lockout: three timed-out attempts -> lockout=1 for exactly 10 cycles; arm pulses during lockout have no effect; exit to S_IDLE with fail_cnt=0.
- Simultaneous events: det_out=1 on the same cycle as timer expiry in S_ARMED -> S_UNLOCK, fail_cnt unchanged-to-0, no S_FAIL visit. relock at cycle 2 of S_UNLOCK -> S_IDLE next cycle.
- SEQ_LOCK_AUTO_REARM_EN defined: first timeout -> S_FAIL for 1 cycle, then S_ARMED with det_clr=0 and no arm needed. Third failure still enters S_LOCKOUT.
